// File: rtl/kronos_branch_ctrl.sv
// Branch resolution controller: accepts one conditional branch, resolves it on a
// registered copy of the operands, reports the outcome and redirects fetch on a mispredict.

module kronos_branch (
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1_i == rs2_i);
    assign lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu = (rs1_i < rs2_i);

    // 010/011 are not legal branches; they fall onto the BLT/BLTU comparators.
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            3'b000:          taken_o = eq;
            3'b001:          taken_o = ~eq;
            3'b010, 3'b100:  taken_o = lt;
            3'b101:          taken_o = ~lt;
            3'b011, 3'b110:  taken_o = ltu;
            3'b111:          taken_o = ~ltu;
            default:         taken_o = 1'b0;
        endcase
    end

endmodule

module kronos_branch_ctrl #(
    parameter int CNT_W      = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_vld,
    output logic             br_rdy,
    input  logic [2:0]       br_op,
    input  logic [31:0]      br_rs1,
    input  logic [31:0]      br_rs2,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_offset,
    input  logic             br_pred_taken,
    output logic             res_vld,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             res_misalign,
    output logic             redir_vld,
    input  logic             redir_rdy,
    output logic [31:0]      redir_addr,
    output logic             flush,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    state_e state_q;

    logic [2:0]       op_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [31:0]      pc_q;
    logic [31:0]      offset_q;
    logic             pred_q;

    logic             br_rdy_q;
    logic             res_vld_q;
    logic             res_taken_q;
    logic             res_mispredict_q;
    logic             res_misalign_q;
    logic             redir_vld_q;
    logic [31:0]      redir_addr_q;
    logic [CNT_W-1:0] branches_q;
    logic [CNT_W-1:0] mispredicts_q;

    logic             taken_d;
    logic [31:0]      target_d;
    logic             misalign_d;
    logic             mispredict_d;

    // The comparator only ever sees the latched operands, so decode may change
    // its outputs freely once the request has been accepted.
    kronos_branch u_branch (
        .op_i    (op_q),
        .rs1_i   (rs1_q),
        .rs2_i   (rs2_q),
        .taken_o (taken_d)
    );

    always_comb begin
        target_d     = taken_d ? (pc_q + offset_q) : (pc_q + 32'(ILEN_BYTES));
        misalign_d   = taken_d & (target_d[1:0] != 2'b00);
        mispredict_d = (taken_d != pred_q) & ~misalign_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            op_q             <= '0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            pc_q             <= '0;
            offset_q         <= '0;
            pred_q           <= 1'b0;
            br_rdy_q         <= 1'b1;
            res_vld_q        <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_misalign_q   <= 1'b0;
            redir_vld_q      <= 1'b0;
            redir_addr_q     <= '0;
            branches_q       <= '0;
            mispredicts_q    <= '0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (br_vld) begin
                        op_q     <= br_op;
                        rs1_q    <= br_rs1;
                        rs2_q    <= br_rs2;
                        pc_q     <= br_pc;
                        offset_q <= br_offset;
                        pred_q   <= br_pred_taken;
                        br_rdy_q <= 1'b0;
                        state_q  <= EVAL;
                    end
                end
                EVAL: begin
                    res_vld_q        <= 1'b1;
                    res_taken_q      <= taken_d;
                    res_mispredict_q <= mispredict_d;
                    res_misalign_q   <= misalign_d;
                    branches_q       <= branches_q + CNT_W'(1);
                    if (mispredict_d) begin
                        mispredicts_q <= mispredicts_q + CNT_W'(1);
                        redir_addr_q  <= target_d;
                        redir_vld_q   <= 1'b1;
                        state_q       <= REDIRECT;
                    end else begin
                        br_rdy_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                REDIRECT: begin
                    // redir_addr stays put until fetch takes it.
                    if (redir_rdy) begin
                        redir_vld_q <= 1'b0;
                        br_rdy_q    <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    redir_vld_q <= 1'b0;
                    br_rdy_q    <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign br_rdy           = br_rdy_q;
    assign res_vld          = res_vld_q;
    assign res_taken        = res_taken_q;
    assign res_mispredict   = res_mispredict_q;
    assign res_misalign     = res_misalign_q;
    assign redir_vld        = redir_vld_q;
    assign redir_addr       = redir_addr_q;
    assign flush            = redir_vld_q & redir_rdy;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_kronos_branch_ctrl.sv
// Directed bench for kronos_branch_ctrl: resolved results and redirect addresses
// are queued by the driver and checked by an independent monitor.

module tb_kronos_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_vld = 1'b0;
    logic        br_rdy;
    logic [2:0]  br_op = '0;
    logic [31:0] br_rs1 = '0;
    logic [31:0] br_rs2 = '0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_offset = '0;
    logic        br_pred_taken = 1'b0;
    logic        res_vld;
    logic        res_taken;
    logic        res_mispredict;
    logic        res_misalign;
    logic        redir_vld;
    logic        redir_rdy = 1'b1;
    logic [31:0] redir_addr;
    logic        flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    typedef struct packed {
        logic        taken;
        logic        misp;
        logic        mis;
        logic [31:0] nbr;
        logic [31:0] nmp;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] redir_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    kronos_branch_ctrl #(.CNT_W(32), .ILEN_BYTES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .br_vld           (br_vld),
        .br_rdy           (br_rdy),
        .br_op            (br_op),
        .br_rs1           (br_rs1),
        .br_rs2           (br_rs2),
        .br_pc            (br_pc),
        .br_offset        (br_offset),
        .br_pred_taken    (br_pred_taken),
        .res_vld          (res_vld),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .res_misalign     (res_misalign),
        .redir_vld        (redir_vld),
        .redir_rdy        (redir_rdy),
        .redir_addr       (redir_addr),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every res_vld and every flush must match a queued expectation.
    initial begin
        res_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!rst && res_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_vld", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_taken", {31'd0, res_taken}, {31'd0, e.taken});
                    check("res_mispredict", {31'd0, res_mispredict}, {31'd0, e.misp});
                    check("res_misalign", {31'd0, res_misalign}, {31'd0, e.mis});
                    check("stat_branches", stat_branches, e.nbr);
                    check("stat_mispredicts", stat_mispredicts, e.nmp);
                end
            end
            if (!rst && flush) begin
                if (redir_q.size() == 0) begin
                    check("unexpected_flush", 32'd1, 32'd0);
                end else begin
                    a = redir_q.pop_front();
                    check("redir_addr", redir_addr, a);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] off, input logic pred,
                        input logic e_taken, input logic e_misp, input logic e_mis,
                        input logic [31:0] e_br, input logic [31:0] e_mp, input logic [31:0] e_addr);
        res_t e;
        int   waited = 0;
        @(negedge clk);
        while (!br_rdy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!br_rdy) check("br_rdy_timeout", 32'd0, 32'd1);
        e.taken = e_taken; e.misp = e_misp; e.mis = e_mis; e.nbr = e_br; e.nmp = e_mp;
        exp_q.push_back(e);
        if (e_misp) redir_q.push_back(e_addr);
        br_vld = 1'b1; br_op = op; br_rs1 = rs1; br_rs2 = rs2;
        br_pc = pc; br_offset = off; br_pred_taken = pred;
        @(posedge clk);
        #1;
        // Scramble live inputs so any use of them after acceptance shows up.
        br_vld = 1'b0; br_op = 3'($urandom_range(0, 7));
        br_rs1 = $urandom; br_rs2 = $urandom; br_pc = $urandom; br_offset = $urandom;
        br_pred_taken = ~pred;
    endtask

    // Full branch with redir_rdy held high: latency, redirect and flush pulse.
    task automatic run_branch(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] off, input logic pred,
                              input logic e_taken, input logic e_misp, input logic e_mis,
                              input logic [31:0] e_br, input logic [31:0] e_mp, input logic [31:0] e_addr);
        send(op, rs1, rs2, pc, off, pred, e_taken, e_misp, e_mis, e_br, e_mp, e_addr);
        @(negedge clk);
        check("eval_br_rdy", {31'd0, br_rdy}, 32'd0);
        check("eval_res_vld", {31'd0, res_vld}, 32'd0);
        @(negedge clk);
        check("n2_res_vld", {31'd0, res_vld}, 32'd1);
        check("n2_redir_vld", {31'd0, redir_vld}, {31'd0, e_misp});
        check("n2_flush", {31'd0, flush}, {31'd0, e_misp});
        check("n2_br_rdy", {31'd0, br_rdy}, {31'd0, ~e_misp});
        if (e_misp) begin
            @(negedge clk);
            check("post_flush", {31'd0, flush}, 32'd0);
            check("post_redir_vld", {31'd0, redir_vld}, 32'd0);
            check("post_br_rdy", {31'd0, br_rdy}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_br_rdy", {31'd0, br_rdy}, 32'd1);
        check("rst_res_vld", {31'd0, res_vld}, 32'd0);
        check("rst_redir_vld", {31'd0, redir_vld}, 32'd0);
        check("rst_redir_addr", redir_addr, 32'd0);
        check("rst_stat_branches", stat_branches, 32'd0);
        check("rst_stat_mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, predicted taken
        run_branch(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b1, 1, 0, 0, 1, 0, 32'h0);
        // BLT signed -1 < 1, predicted not taken: wrap back to 0x1F0
        run_branch(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 1'b0, 1, 1, 0, 2, 1, 32'h1F0);

        // BLTU same operands, predicted taken; fetch stalls the redirect
        redir_rdy = 1'b0;
        send(3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 1'b1, 0, 1, 0, 3, 2, 32'h204);
        @(negedge clk);
        @(negedge clk);
        check("hold_redir_vld0", {31'd0, redir_vld}, 32'd1);
        check("hold_br_rdy0", {31'd0, br_rdy}, 32'd0);
        br_vld = 1'b1; br_op = 3'b000; br_rs1 = 32'h5; br_rs2 = 32'h5;
        br_pc = 32'h900; br_offset = 32'h8; br_pred_taken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_redir_vld", {31'd0, redir_vld}, 32'd1);
            check("hold_redir_addr", redir_addr, 32'h204);
            check("hold_br_rdy", {31'd0, br_rdy}, 32'd0);
            check("hold_flush", {31'd0, flush}, 32'd0);
        end
        @(posedge clk);
        #1;
        redir_rdy = 1'b1;
        br_vld = 1'b0;
        @(negedge clk);
        check("release_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        check("release_flush_off", {31'd0, flush}, 32'd0);
        check("release_redir_vld", {31'd0, redir_vld}, 32'd0);
        check("release_br_rdy", {31'd0, br_rdy}, 32'd1);
        check("release_branches", stat_branches, 32'd3);

        // BNE taken across the top of the address space
        run_branch(3'b001, 32'h1, 32'h2, 32'hFFFFFFF8, 32'h10, 1'b0, 1, 1, 0, 4, 3, 32'h8);
        // BGE taken to a misaligned target: reported, not redirected
        run_branch(3'b101, 32'h5, 32'h5, 32'h300, 32'h6, 1'b0, 1, 0, 1, 5, 3, 32'h0);
        // BGEU unsigned 0x80000000 >= 1, correctly predicted
        run_branch(3'b111, 32'h80000000, 32'h1, 32'h400, 32'h8, 1'b1, 1, 0, 0, 6, 3, 32'h0);
        // BGE signed 0x80000000 >= 1 is false, correctly predicted
        run_branch(3'b101, 32'h80000000, 32'h1, 32'h500, 32'h40, 1'b0, 0, 0, 0, 7, 3, 32'h0);
        // BNE equal operands, predicted taken: redirect to fall-through
        run_branch(3'b001, 32'h77, 32'h77, 32'h600, 32'h40, 1'b1, 0, 1, 0, 8, 4, 32'h604);

        // Reset while a redirect is pending
        redir_rdy = 1'b0;
        send(3'b000, 32'h1, 32'h2, 32'h800, 32'h10, 1'b1, 0, 1, 0, 9, 5, 32'h804);
        @(negedge clk);
        @(negedge clk);
        check("prerst_redir_vld", {31'd0, redir_vld}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        redir_q.delete();
        check("midrst_redir_vld", {31'd0, redir_vld}, 32'd0);
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_br_rdy", {31'd0, br_rdy}, 32'd1);
        check("midrst_res_vld", {31'd0, res_vld}, 32'd0);
        check("midrst_redir_addr", redir_addr, 32'd0);
        check("midrst_branches", stat_branches, 32'd0);
        check("midrst_mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        redir_rdy = 1'b1;

        // Counters restart after reset
        run_branch(3'b000, 32'hABCD, 32'hABCD, 32'h100, 32'h20, 1'b1, 1, 0, 0, 1, 0, 32'h0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("redir_q_drained", redir_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_branch_ctrl.md
Name: kronos_branch_ctrl

Overview:
Branch resolution controller between decode and fetch. It accepts one conditional branch at a time over a valid/ready handshake, evaluates it on a single internal instance of the `kronos_branch` comparator, and computes the next PC. It compares the outcome with the fetch-stage prediction and, on a mispredict, issues a held redirect to fetch with a one-cycle flush. It also keeps branch and mispredict statistics counters.

Parameters:
- CNT_W, 32, width of the statistics counters.
- ILEN_BYTES, 4, fall-through increment added to the PC when the branch is not taken.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- br_vld  in  1  branch request valid.
- br_rdy  out  1  controller can accept a request.
- br_op  in  3  funct3 of the branch: BEQ, BNE, BLT, BGE, BLTU or BGEU.
- br_rs1  in  32  first operand.
- br_rs2  in  32  second operand.
- br_pc  in  32  PC of the branch instruction.
- br_offset  in  32  sign-extended B-immediate.
- br_pred_taken  in  1  fetch predicted taken.
- res_vld  out  1  one-cycle pulse: the branch is resolved.
- res_taken  out  1  resolved direction; valid with res_vld.
- res_mispredict  out  1  direction differs from prediction; valid with res_vld.
- res_misalign  out  1  taken target is not 4-byte aligned; valid with res_vld.
- redir_vld  out  1  redirect request to fetch.
- redir_rdy  in  1  fetch accepts the redirect.
- redir_addr  out  32  correct next PC.
- flush  out  1  pipeline flush, asserted when redir_vld and redir_rdy are both high.
- stat_branches  out  CNT_W  count of resolved branches.
- stat_mispredicts  out  CNT_W  count of redirected branches.

Behaviour:
- Reset is asynchronous and active-high.
  - State returns to IDLE.
  - All outputs reset to 0 except br_rdy, which is 1 (IDLE).
  - Latched operands and redir_addr reset to 0.
- FSM states: IDLE, EVAL, REDIRECT.
- IDLE:
  - br_rdy = 1.
  - On br_vld & br_rdy, latch op, rs1, rs2, pc, offset and pred_taken, then go to EVAL.
  - Inputs are ignored when br_vld = 0.
- EVAL (exactly one cycle):
  - br_rdy = 0.
  - The comparator instance sees only the latched op/rs1/rs2, never the live inputs.
  - taken = comparator output.
  - target = pc + offset if taken, else pc + ILEN_BYTES. Arithmetic is modulo 2^32, so wrap-around is legal.
  - misalign = taken & (target[1:0] != 0).
  - mispredict = (taken != pred_taken) & ~misalign.
  - res_vld is registered and pulses in the cycle after EVAL, together with res_taken, res_mispredict and res_misalign.
  - stat_branches increments by 1 on every EVAL.
  - stat_mispredicts increments by 1 when mispredict is set.
  - Both counters wrap at 2^CNT_W.
  - If mispredict: register redir_addr = target and go to REDIRECT. Otherwise go to IDLE.
  - A misaligned branch never redirects; the trap is handled downstream.
- REDIRECT:
  - redir_vld = 1; redir_addr is held stable; br_rdy = 0.
  - Stays in this state indefinitely while redir_rdy = 0.
  - On redir_rdy, flush = 1 for that cycle; go to IDLE, and redir_vld drops next cycle.
- Latency: accept in cycle N → EVAL in N+1 → res_vld and (if mispredicted) redir_vld in N+2 → br_rdy high again in N+2 for a correct prediction.
- Throughput: at most one branch every 2 cycles; no request is accepted while a redirect is pending.
- Reset asserted mid-operation drops any in-flight branch and pending redirect. No flush or res_vld is generated for it, and the counters are cleared.
- br_op values 010 and 011 are not valid branches; they evaluate as BLT/BLTU, and decode must not issue them.

Test Plan:
- BEQ rs1 = rs2 = 0x1234, pc = 0x100, offset = 0x20, pred = 1:
  - res_vld 2 cycles after accept with taken = 1, mispredict = 0.
  - No redir_vld; br_rdy = 1 at N+2; stat_branches = 1.
- BLT rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x200, offset = 0xFFFFFFF0, pred = 0:
  - taken = 1, mispredict = 1.
  - redir_vld with redir_addr = 0x1F0; with redir_rdy = 1, flush pulses for exactly one cycle.
  - stat_mispredicts = 1.
- BLTU with the same operands, pred = 1:
  - taken = 0, mispredict = 1, redir_addr = 0x204.
- Hold redir_rdy = 0 for 5 cycles:
  - redir_vld and redir_addr stay stable; br_rdy = 0; br_vld is ignored.
  - On release, flush is a one-cycle pulse and br_rdy returns to 1 the next cycle.
- BNE taken with pc = 0xFFFFFFF8, offset = 0x10:
  - redir_addr = 0x00000008 (modulo 2^32 wrap).
- BGE taken with offset = 0x6:
  - res_misalign = 1, mispredict = 0, no redirect, stat_mispredicts unchanged.
- Assert rst during REDIRECT:
  - Outputs immediately return to reset values: redir_vld = 0, flush = 0, counters = 0.
  - br_rdy = 1.
